// File: rtl/muldiv_seq_pkg.sv
// Shared types and decode helpers for the sequential RV32M multiply/divide unit.
package muldiv_seq_pkg;

  localparam int unsigned XlenDefault = 32;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIter = 3'd1,
    StFix  = 3'd2,
    StSpec = 3'd3,
    StDone = 3'd4
  } state_e;

  // RV32M funct3 encodings
  typedef enum logic [2:0] {
    FnMul    = 3'b000,
    FnMulh   = 3'b001,
    FnMulhsu = 3'b010,
    FnMulhu  = 3'b011,
    FnDiv    = 3'b100,
    FnDivu   = 3'b101,
    FnRem    = 3'b110,
    FnRemu   = 3'b111
  } funct_e;

  // Divide/remainder group is funct[2]; remainder ops also have funct[1] set.
  function automatic logic fn_is_div(logic [2:0] f);
    return f[2];
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
  function automatic logic fn_signed_a(logic [2:0] f);
    return f[2] ? ~f[0] : (f != FnMulhu);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM.
  function automatic logic fn_signed_b(logic [2:0] f);
    return f[2] ? ~f[0] : ~f[1];
  endfunction

  // Upper word of the product, or the remainder, is the returned word.
  function automatic logic fn_sel_hi(logic [2:0] f);
    return f[2] ? f[1] : (f != FnMul);
  endfunction

endpackage

// File: rtl/muldiv_seq_dp.sv
// Datapath: double-width accumulator, one shared add/subtract unit, and result fix-up.
module muldiv_seq_dp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] opr_in,
  input  logic            neg_wide,
  input  logic            sel_hi,
  input  logic            neg_word,
  output logic [XLEN-1:0] fix_word
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opr_q, opr_d;
  logic [XLEN:0]     add_a, add_b, sum;
  logic              sub, div_ge;
  logic [2*XLEN-1:0] wide;
  logic [XLEN-1:0]   word;

  // Shared (XLEN+1)-bit adder: upper half + multiplicand, or shifted remainder - divisor
  always_comb begin
    sub   = is_div;
    add_a = is_div ? {1'b0, acc_q[2*XLEN-2:XLEN-1]} : {1'b0, acc_q[2*XLEN-1:XLEN]};
    add_b = {1'b0, opr_q};
    sum   = add_a + (sub ? ~add_b : add_b) + {{XLEN{1'b0}}, sub};
    // A set top bit means the shifted remainder already exceeds any divisor.
    div_ge = acc_q[2*XLEN-1] | ~sum[XLEN];
  end

  // Accumulator next state: load operands, or one multiply/divide step
  always_comb begin
    acc_d = acc_q;
    opr_d = opr_q;
    if (load) begin
      acc_d = {{XLEN{1'b0}}, lo_in};
      opr_d = opr_in;
    end else if (step) begin
      if (is_div) begin
        acc_d = div_ge ? {sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
      end else begin
        acc_d = acc_q[0] ? {sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      end
    end
  end

  // Sign fix-up and word select for the final result
  always_comb begin
    wide     = neg_wide ? -acc_q : acc_q;
    word     = sel_hi ? wide[2*XLEN-1:XLEN] : wide[XLEN-1:0];
    fix_word = neg_word ? -word : word;
  end

  // Accumulator and operand registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      opr_q <= '0;
    end else begin
      acc_q <= acc_d;
      opr_q <= opr_d;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M MUL/DIV sequencer: one bit per cycle, sign fix-up, done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      funct_q, funct_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0] spec_q, spec_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d, busy_q, busy_d;

  logic            in_sign_a, in_sign_b, div_zero, div_ovf, is_spec;
  logic [XLEN-1:0] mag_a, mag_b, spec_word, dp_lo_in, dp_opr_in, fix_word;
  logic            dp_load, dp_step, neg_wide, neg_word, is_div_q;

  // Decode of the incoming request: magnitudes, signs and special-case detection
  always_comb begin
    in_sign_a = fn_signed_a(funct) & rs1[XLEN-1];
    in_sign_b = fn_signed_b(funct) & rs2[XLEN-1];
    mag_a     = in_sign_a ? -rs1 : rs1;
    mag_b     = in_sign_b ? -rs2 : rs2;
    div_zero  = (rs2 == '0);
    div_ovf   = fn_is_div(funct) & ~funct[0] & (rs1 == MinInt) & (rs2 == '1);
    is_spec   = fn_is_div(funct) & (div_zero | div_ovf);
    spec_word = div_zero ? (funct[1] ? rs1 : '1) : (funct[1] ? '0 : MinInt);
    // Multiplier goes in the low half; dividend goes in the low half.
    dp_lo_in  = fn_is_div(funct) ? mag_a : mag_b;
    dp_opr_in = fn_is_div(funct) ? mag_b : mag_a;
  end

  // Fix-up controls from the latched op
  always_comb begin
    is_div_q = fn_is_div(funct_q);
    neg_wide = ~is_div_q & (sign_a_q ^ sign_b_q);
    neg_word = is_div_q & (funct_q[1] ? sign_a_q : (sign_a_q ^ sign_b_q));
  end

  // FSM next state, counter, latched op fields and registered outputs
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    funct_d  = funct_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    spec_d   = spec_q;
    result_d = result_q;
    dp_load  = 1'b0;
    dp_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !kill) begin
          funct_d  = funct;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          spec_d   = spec_word;
          count_d  = '0;
          dp_load  = 1'b1;
          state_d  = is_spec ? StSpec : StIter;
        end
      end
      StIter: begin
        dp_step = 1'b1;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) state_d = StFix;
      end
      StFix: begin
        result_d = fix_word;
        state_d  = StDone;
      end
      StSpec: begin
        result_d = spec_q;
        state_d  = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Flush abandons the op without touching the result.
    if (kill && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
      dp_step  = 1'b0;
    end
    done_d = (state_d == StDone);
    busy_d = (state_d != StIdle);
  end

  // State and control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      funct_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      spec_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      funct_q  <= funct_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  muldiv_seq_dp #(
    .XLEN(XLEN)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (dp_load),
    .step    (dp_step),
    .is_div  (is_div_q),
    .lo_in   (dp_lo_in),
    .opr_in  (dp_opr_in),
    .neg_wide(neg_wide),
    .sel_hi  (fn_sel_hi(funct_q)),
    .neg_word(neg_word),
    .fix_word(fix_word)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  // Hold the pipeline the same cycle a request is presented.
  assign stall  = busy_q | (start & (state_q == StIdle));

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: latency/result model plus directed literal cases.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct = 3'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail = 0;

  // Model state: remaining busy cycles (0 = idle), pending and visible result
  int          m_left = 0;
  logic [31:0] m_pending = '0;
  logic [31:0] m_result = '0;

  muldiv_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .kill  (kill),
    .funct (funct),
    .rs1   (rs1),
    .rs2   (rs2),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint          ub = longint'({32'b0, b});
    longint unsigned uu = {32'b0, a};
    longint unsigned vv = {32'b0, b};
    logic [63:0]     p;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = uu * vv; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = uu / vv; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = uu % vv; return p[31:0];
      end
    endcase
  endfunction

  // Busy cycles after acceptance: special divides finish quickly
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0)) return 2;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Behavioural timeline model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_result <= '0;
    end else if (m_left > 0) begin
      if (kill) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 2) m_result <= m_pending;
      end
    end else if (start && !kill) begin
      m_left    <= ref_lat(funct, rs1, rs2);
      m_pending <= ref_op(funct, rs1, rs2);
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      check("busy", {31'b0, busy}, {31'b0, m_left > 0});
      check("done", {31'b0, done}, {31'b0, m_left == 1});
      check("stall", {31'b0, stall}, {31'b0, (m_left > 0) || start});
      check("result", result, m_result);
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from idle, then confirm latency and result literals
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat = -1;
    @(negedge clk);
    start = 1'b1; kill = 1'b0; funct = f; rs1 = a; rs2 = b;
    #2;
    check({name, "/stall0"}, {31'b0, stall}, 32'd1);
    check({name, "/busy0"}, {31'b0, busy}, 32'd0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; funct = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      end
      #2;
      if (done) begin lat = k; break; end
    end
    check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/value"}, result, exp_res);
  endtask

  initial begin
    int seen_done;
    int lat;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #2;
    check("reset/busy", {31'b0, busy}, 32'd0);
    check("reset/done", {31'b0, done}, 32'd0);
    check("reset/result", result, 32'd0);

    run_op("mul7x6", 3'd0, 32'd7, 32'd6, 32'd42, 34);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);
    run_op("divu_100_7b", 3'd5, 32'd100, 32'd7, 32'd14, 34);

    // Flush mid-iteration, then restart on the very next cycle
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; funct = 3'd0; rs1 = 32'd7; rs2 = 32'd6;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
      kill = (k == 10);
      if (k == 11) begin
        start = 1'b1; funct = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      end
      #2;
      if (done) seen_done++;
    end
    check("kill/busy", {31'b0, busy}, 32'd0);
    check("kill/no_done", 32'(seen_done), 32'd0);
    check("kill/result_held", result, 32'd14);
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      if (done) begin lat = k; break; end
    end
    check("kill/restart_lat", 32'(lat), 32'd34);
    check("kill/restart_val", result, 32'd81);

    // Asynchronous reset between edges in the middle of an op
    @(negedge clk);
    start = 1'b1; funct = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check("arst/busy", {31'b0, busy}, 32'd0);
    check("arst/done", {31'b0, done}, 32'd0);
    check("arst/result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("arst/after", 3'd0, 32'd3, 32'd5, 32'd15, 34);

    // Randomized traffic: starts while busy, flushes, special operands
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      kill  = ($urandom_range(0, 63) == 0);
      funct = 3'($urandom);
      rs1   = rnd_opnd();
      rs2   = rnd_opnd();
    end
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    for (int k = 0; k < 60 && m_left > 0; k++) @(negedge clk);
    check("drain/idle", 32'(m_left), 32'd0);
    repeat (2) @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
